// File: rtl/mem_rd_sched_pkg.sv
// Shared types and helpers for the round-robin MEM burst read scheduler.
package mem_rd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Distance of requester i behind the round-robin pointer: ptr+1 -> 0, ptr -> n-1.
  function automatic int rr_dist(input int i, input int ptr, input int n);
    return (i > ptr) ? (i - ptr - 1) : (i + n - ptr - 1);
  endfunction

endpackage

// File: rtl/mem_rd_sched_rr_arbiter.sv
// Combinational round-robin pick: the requester closest after ptr_i wins.
module mem_rd_sched_rr_arbiter
  import mem_rd_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int LOG_NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [LOG_NUM_REQ-1:0] ptr_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [LOG_NUM_REQ-1:0] idx_o,
  output logic                   valid_o
);

  always_comb begin
    int best_d;
    best_d = NUM_REQ;
    idx_o  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_i[i] && (rr_dist(i, int'(ptr_i), NUM_REQ) < best_d)) begin
        best_d = rr_dist(i, int'(ptr_i), NUM_REQ);
        idx_o  = LOG_NUM_REQ'(i);
      end
    end
    valid_o = |req_i;
    gnt_o   = valid_o ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/mem_rd_sched.sv
// Shares one MEM read port among NUM_REQ burst requesters, round-robin, one read per cycle.
// Handshake: req is held until a one-cycle ack; addr/len are latched on that ack, done pulses with the last word.
module mem_rd_sched
  import mem_rd_sched_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int LOG_NUM_REQ     = 2,
  parameter int DATA_WIDTH      = 8,
  parameter int LOG_MAX_ADDRESS = 16,
  parameter int LEN_WIDTH       = 17
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ*LOG_MAX_ADDRESS-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]         req_len,
  output logic [NUM_REQ-1:0]                   ack,
  output logic [NUM_REQ-1:0]                   done,
  output logic [NUM_REQ-1:0]                   rd_valid,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic                                 busy,
  output logic [LOG_MAX_ADDRESS-1:0]           mem_addr,
  output logic                                 mem_read,
  input  logic [DATA_WIDTH-1:0]                mem_data,
  input  logic                                 mem_valid,
  output state_e                               dbg_state
);

  state_e                     state_q, state_d;
  logic [LOG_NUM_REQ-1:0]     owner_q, owner_d;
  logic [LOG_NUM_REQ-1:0]     rr_ptr_q, rr_ptr_d;
  logic [LOG_MAX_ADDRESS-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]       remain_q, remain_d;

  logic [NUM_REQ-1:0]         gnt_oh;
  logic [LOG_NUM_REQ-1:0]     gnt_idx;
  logic                       gnt_any;
  logic [LOG_MAX_ADDRESS-1:0] gnt_addr;
  logic [LEN_WIDTH-1:0]       gnt_len;
  logic [NUM_REQ-1:0]         owner_oh;

  mem_rd_sched_rr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .LOG_NUM_REQ(LOG_NUM_REQ)
  ) u_arb (
    .req_i  (req),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (gnt_oh),
    .idx_o  (gnt_idx),
    .valid_o(gnt_any)
  );

  always_comb begin
    gnt_addr = '0;
    gnt_len  = '0;
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == LOG_NUM_REQ'(i)) begin
        gnt_addr = req_addr[i*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS];
        gnt_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
      owner_oh[i] = (owner_q == LOG_NUM_REQ'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= LOG_NUM_REQ'(NUM_REQ - 1);
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  // ack is gated by rst so a held req cannot pulse ack while the block is in reset.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    ack      = '0;
    done     = '0;
    mem_read = 1'b0;
    mem_addr = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any && rst) begin
          ack      = gnt_oh;
          owner_d  = gnt_idx;
          rr_ptr_d = gnt_idx;
          addr_d   = gnt_addr;
          remain_d = gnt_len;
          state_d  = (gnt_len == '0) ? ST_DRAIN : ST_BURST;
        end
      end
      ST_BURST: begin
        mem_read = 1'b1;
        mem_addr = addr_q;
        addr_d   = addr_q + LOG_MAX_ADDRESS'(1);
        remain_d = remain_q - LEN_WIDTH'(1);
        if (remain_q == LEN_WIDTH'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        done    = owner_oh;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Words returning in IDLE belong to an aborted burst and are dropped.
  always_comb begin
    rd_valid = '0;
    if (mem_valid && (state_q == ST_BURST || state_q == ST_DRAIN)) rd_valid = owner_oh;
  end

  assign rd_data   = mem_data;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_rd_sched.sv
// Bench for mem_rd_sched: behavioural MEM (mem[i]=i) plus a round-robin/timing reference model.
module tb_mem_rd_sched;
  import mem_rd_sched_pkg::*;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int LW = 9;
  localparam int DW = 8;

  logic              clk, rst;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*LW-1:0]  req_len;
  logic [NR-1:0]     ack, done, rd_valid;
  logic [DW-1:0]     rd_data, mem_data;
  logic              busy, mem_read, mem_valid;
  logic [AW-1:0]     mem_addr;
  state_e            dbg_state;

  int vectors;
  int miscompares;
  int model_ptr;
  logic [DW-1:0] mem [256];

  mem_rd_sched #(
    .NUM_REQ(NR), .LOG_NUM_REQ(2), .DATA_WIDTH(DW), .LOG_MAX_ADDRESS(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len),
    .ack(ack), .done(done), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_data(mem_data), .mem_valid(mem_valid),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MEM with one-cycle read latency, not reset by rst
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'(i);
    mem_valid = 1'b0;
    mem_data  = '0;
  end
  always @(posedge clk) begin
    mem_valid <= mem_read;
    if (mem_read) mem_data <= mem[mem_addr];
  end

  // one-hot and busy invariants every cycle
  always @(negedge clk) begin
    vectors++;
    if (!$onehot0(ack) || !$onehot0(done) || !$onehot0(rd_valid) ||
        (((|rd_valid) || (|done) || mem_read) && !busy)) begin
      miscompares++;
      $display("FAIL invariant: ack=%b done=%b rd_valid=%b mem_read=%b busy=%b", ack, done, rd_valid, mem_read, busy);
    end
  end

  function automatic int pick(input logic [NR-1:0] r, input int ptr);
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (ptr + k) % NR;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_slot(input int i, input int a, input int l);
    req_addr[i*AW +: AW] = AW'(a);
    req_len[i*LW +: LW]  = LW'(l);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_ptr = NR - 1;
  endtask

  // Waits for ack of 'who', then checks every cycle of the burst against the timing rules.
  task automatic run_burst(input int who, input int addr, input int len,
                           input logic [NR-1:0] req_after, input int budget, input string tag);
    bit got;
    logic [NR-1:0] own;
    got = 1'b0;
    own = NR'(1) << who;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (ack != '0) got = 1'b1;
    end
    vectors++;
    if (!got || ack !== own || busy !== 1'b0 || mem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL %s ack: got ack=%b busy=%b mem_read=%b, want ack=%b busy=0 mem_read=0", tag, ack, busy, mem_read, own);
    end
    if (!got) return;
    @(posedge clk);
    #1;
    req = req_after;
    if (!req_after[who]) set_slot(who, int'($urandom_range(0, 255)), int'($urandom_range(0, 6)));
    for (int j = 1; j <= len + 1; j++) begin
      logic          e_read;
      logic [AW-1:0] e_addr;
      logic [NR-1:0] e_valid, e_done;
      logic [DW-1:0] e_data;
      @(negedge clk);
      e_read  = (j <= len);
      e_addr  = e_read ? AW'(addr + j - 1) : '0;
      e_valid = (j >= 2) ? own : '0;
      e_done  = (j == len + 1) ? own : '0;
      e_data  = DW'(addr + j - 2);
      vectors++;
      if ({ack, mem_read, mem_addr, rd_valid, done, busy} !== {{NR{1'b0}}, e_read, e_addr, e_valid, e_done, 1'b1}) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got ack=%b rd=%b addr=%h v=%b d=%b busy=%b, want ack=0000 rd=%b addr=%h v=%b d=%b busy=1",
                 tag, j, ack, mem_read, mem_addr, rd_valid, done, busy, e_read, e_addr, e_valid, e_done);
      end
      if (e_valid != '0) begin
        vectors++;
        if (rd_data !== e_data) begin
          miscompares++;
          $display("FAIL %s data %0d: got %h want %h", tag, j, rd_data, e_data);
        end
      end
    end
    model_ptr = who;
  endtask

  // Raises the requests in r together and serves them in model round-robin order.
  task automatic serve_all(input logic [NR-1:0] r, input int a[NR], input int l[NR], input string tag);
    logic [NR-1:0] pend;
    int w;
    bit first;
    for (int i = 0; i < NR; i++) set_slot(i, a[i], l[i]);
    @(posedge clk);
    #1 req = r;
    pend  = r;
    first = 1'b1;
    while (pend != '0) begin
      w = pick(pend, model_ptr);
      run_burst(w, a[w], l[w], pend & ~(NR'(1) << w), first ? 2 : 1, tag);
      pend  = pend & ~(NR'(1) << w);
      first = 1'b0;
    end
  endtask

  task automatic check_quiet(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      vectors++;
      if ({ack, done, rd_valid, mem_read, busy} !== '0) begin
        miscompares++;
        $display("FAIL %s quiet: got ack=%b done=%b v=%b rd=%b busy=%b, want all 0", tag, ack, done, rd_valid, mem_read, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < NR; i++) set_slot(i, 16 * i, 3);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if ({ack, done, rd_valid, busy, mem_read, mem_addr, dbg_state} !== '0) begin
        miscompares++;
        $display("FAIL reset: got ack=%b done=%b v=%b busy=%b rd=%b addr=%h st=%0d, want all 0",
                 ack, done, rd_valid, busy, mem_read, mem_addr, dbg_state);
      end
    end
    req = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    model_ptr = NR - 1;
    check_quiet(2, "after_reset");
  endtask

  task automatic test_single();
    int a[NR] = '{0, 0, 'h10, 0};
    int l[NR] = '{0, 0, 4, 0};
    serve_all(4'b0100, a, l, "single");
    check_quiet(1, "single_end");
  endtask

  task automatic test_contention();
    int a[NR] = '{'h20, 'h30, 'h40, 'h50};
    int l[NR] = '{1, 1, 1, 1};
    apply_reset();
    serve_all(4'b1111, a, l, "contention");
  endtask

  task automatic test_wrap();
    int a[NR] = '{0, 'hFE, 0, 0};
    int l[NR] = '{0, 4, 0, 0};
    serve_all(4'b0010, a, l, "wrap");
  endtask

  task automatic test_zero_len();
    int a[NR] = '{0, 'h33, 0, 0};
    int l[NR] = '{0, 0, 0, 0};
    serve_all(4'b0010, a, l, "zero_len");
    check_quiet(1, "zero_len_end");
  endtask

  task automatic test_reset_mid_burst();
    int a[NR] = '{'h05, 0, 'h88, 0};
    int l[NR] = '{2, 0, 1, 0};
    bit got;
    apply_reset();
    set_slot(2, 'h40, 8);
    @(posedge clk);
    #1 req = 4'b0100;
    got = 1'b0;
    for (int c = 0; c < 2 && !got; c++) begin
      @(negedge clk);
      if (ack != '0) got = 1'b1;
    end
    vectors++;
    if (ack !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_mid ack: got %b want 0100", ack);
    end
    @(posedge clk);
    #1 req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({ack, done, rd_valid, busy, mem_read, mem_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid abort: got ack=%b done=%b v=%b busy=%b rd=%b addr=%h, want all 0",
               ack, done, rd_valid, busy, mem_read, mem_addr);
    end
    #1 rst = 1'b1;
    model_ptr = NR - 1;
    #1;
    vectors++;
    if ({rd_valid, done, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid trailing: got v=%b done=%b busy=%b, want 0", rd_valid, done, busy);
    end
    check_quiet(3, "reset_mid");
    serve_all(4'b0101, a, l, "reset_mid_next");
  endtask

  task automatic test_fairness();
    set_slot(0, 'h60, 3);
    set_slot(3, 'h70, 2);
    @(posedge clk);
    #1 req = 4'b0001;
    run_burst(pick(4'b0001, model_ptr), 'h60, 3, 4'b1001, 2, "fair_a");
    run_burst(pick(4'b1001, model_ptr), 'h70, 2, 4'b0001, 1, "fair_b");
    run_burst(pick(4'b0001, model_ptr), 'h60, 3, 4'b0000, 1, "fair_c");
    check_quiet(1, "fair_end");
  endtask

  task automatic test_random();
    int a[NR];
    int l[NR];
    logic [NR-1:0] r;
    for (int round = 0; round < 10; round++) begin
      r = NR'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++) begin
        a[i] = int'($urandom_range(0, 255));
        l[i] = int'($urandom_range(0, 5));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      serve_all(r, a, l, "random");
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_ptr   = NR - 1;
    req         = '0;
    req_addr    = '0;
    req_len     = '0;
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_zero_len();
    test_reset_mid_burst();
    test_fairness();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
